// File: rtl/div_unit_if.sv
// Start/busy/done handshake and operand/result bundle for div_unit.
// oDivZero exists only when DIV_ZERO_DETECT_EN is defined.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic             iSigned;
  logic [WIDTH-1:0] iDividend;
  logic [WIDTH-1:0] iDivisor;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oQuotient;
  logic [WIDTH-1:0] oRemainder;
`ifdef DIV_ZERO_DETECT_EN
  logic             oDivZero;

  modport master (
    output iStart, iSigned, iDividend, iDivisor,
    input  oBusy, oDone, oQuotient, oRemainder, oDivZero
  );
  modport slave (
    input  iStart, iSigned, iDividend, iDivisor,
    output oBusy, oDone, oQuotient, oRemainder, oDivZero
  );
`else
  modport master (
    output iStart, iSigned, iDividend, iDivisor,
    input  oBusy, oDone, oQuotient, oRemainder
  );
  modport slave (
    input  iStart, iSigned, iDividend, iDivisor,
    output oBusy, oDone, oQuotient, oRemainder
  );
`endif
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle, WIDTH+1 cycles.
// Optional DIV_ZERO_DETECT_EN: zero divisor short-cuts IDLE->FIX and raises oDivZero.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       iClk,
  input  logic       iRst_n,
  div_unit_if.slave  bus,
  output logic [1:0] oState
);
  // Handshake: iStart is sampled only while oBusy=0; oBusy stays high from the
  // accepting edge until the edge that raises the one-cycle oDone pulse, after
  // which oQuotient/oRemainder hold until the next completion.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0] remReg, quoReg, divisorReg;
  logic [CW-1:0]    count;
  logic             quoNeg, remNeg;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   shifted, trial;
  logic             trialOk;
`ifdef DIV_ZERO_DETECT_EN
  logic             zeroFlag;
  logic             divisorZero;
`endif

  assign absA    = (bus.iSigned && bus.iDividend[WIDTH-1]) ? -bus.iDividend : bus.iDividend;
  assign absB    = (bus.iSigned && bus.iDivisor[WIDTH-1])  ? -bus.iDivisor  : bus.iDivisor;
  // Shifted remainder is below 2*divisor, so WIDTH+1 bits hold both it and the sign of the trial.
  assign shifted = {remReg, quoReg[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisorReg};
  assign trialOk = ~trial[WIDTH];
`ifdef DIV_ZERO_DETECT_EN
  assign divisorZero = (bus.iDivisor == '0);
`endif

  assign bus.oBusy = (state != IDLE);
  assign oState    = state;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (bus.iStart) begin
`ifdef DIV_ZERO_DETECT_EN
          stateNext = divisorZero ? FIX : CALC;
`else
          stateNext = CALC;
`endif
        end
      end
      CALC:    if (count == LAST) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state          <= IDLE;
      count          <= '0;
      remReg         <= '0;
      quoReg         <= '0;
      divisorReg     <= '0;
      quoNeg         <= 1'b0;
      remNeg         <= 1'b0;
      bus.oDone      <= 1'b0;
      bus.oQuotient  <= '0;
      bus.oRemainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      zeroFlag       <= 1'b0;
      bus.oDivZero   <= 1'b0;
`endif
    end else begin
      state     <= stateNext;
      bus.oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            divisorReg <= absB;
            quoReg     <= absA;
            remReg     <= '0;
            count      <= '0;
            quoNeg     <= bus.iSigned & (bus.iDividend[WIDTH-1] ^ bus.iDivisor[WIDTH-1]);
            remNeg     <= bus.iSigned & bus.iDividend[WIDTH-1];
`ifdef DIV_ZERO_DETECT_EN
            zeroFlag   <= divisorZero;
            // Preload the fixed zero-divisor answer so FIX passes it through unsigned.
            if (divisorZero) begin
              quoReg <= '1;
              remReg <= bus.iDividend;
              quoNeg <= 1'b0;
              remNeg <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          remReg <= trialOk ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          quoReg <= {quoReg[WIDTH-2:0], trialOk};
          count  <= count + 1'b1;
        end
        FIX: begin
          bus.oQuotient  <= quoNeg ? -quoReg : quoReg;
          bus.oRemainder <= remNeg ? -remReg : remReg;
          bus.oDone      <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          bus.oDivZero   <= zeroFlag;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: driver pushes expected results into a queue,
// a negedge monitor pops and compares on every oDone.
module tb_div_unit;
  localparam int W = 32;
`ifdef DIV_ZERO_DETECT_EN
  localparam int  DZ_LAT = 1;
  localparam bit  DZ     = 1'b1;
`else
  localparam int  DZ_LAT = 33;
  localparam bit  DZ     = 1'b0;
`endif

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic [1:0] dbgState;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  logic [2*W:0] exp_q[$];  // {divZero, quotient, remainder}
  int           due_q[$];  // cycle on which oDone is expected at the negedge

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus),
    .oState (dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic startDiv(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input bit dz, input int lat);
    int n = 0;
    while (bus.oBusy && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (bus.oBusy) begin
      errors++;
      checks++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", bus.oBusy, n);
    end
    bus.iStart    = 1'b1;
    bus.iSigned   = sgn;
    bus.iDividend = a;
    bus.iDivisor  = b;
    exp_q.push_back({dz, q, r});
    due_q.push_back(cyc + 1 + lat);
    @(negedge iClk);
    bus.iStart    = 1'b0;
    bus.iSigned   = 1'($urandom_range(0, 1));
    bus.iDividend = $urandom;
    bus.iDivisor  = $urandom;
  endtask

  task automatic waitDone();
    int n = 0;
    while (!bus.oDone && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (!bus.oDone) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: oDone still %b after %0d cycles", bus.oDone, n);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge iClk) begin
    if (iRst_n && bus.oDone) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_done: got oDone=1 required no pending result, Q=%h R=%h",
                 bus.oQuotient, bus.oRemainder);
      end else begin
        logic [2*W:0] e;
        int           due;
        e   = exp_q.pop_front();
        due = due_q.pop_front();
        check("quotient",  64'(bus.oQuotient),  64'(e[2*W-1:W]));
        check("remainder", 64'(bus.oRemainder), 64'(e[W-1:0]));
        check("latency",   64'(cyc),            64'(due));
`ifdef DIV_ZERO_DETECT_EN
        check("div_zero",  64'(bus.oDivZero),   64'(e[2*W]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int busyCycles;
    bus.iStart    = 1'b0;
    bus.iSigned   = 1'b0;
    bus.iDividend = '0;
    bus.iDivisor  = '0;
    repeat (3) @(negedge iClk);
    check("rst_busy",      64'(bus.oBusy),      64'd0);
    check("rst_done",      64'(bus.oDone),      64'd0);
    check("rst_quotient",  64'(bus.oQuotient),  64'd0);
    check("rst_remainder", 64'(bus.oRemainder), 64'd0);
    check("rst_state",     64'(dbgState),       64'd0);
`ifdef DIV_ZERO_DETECT_EN
    check("rst_div_zero",  64'(bus.oDivZero),   64'd0);
`endif
    iRst_n = 1'b1;
    repeat (2) @(negedge iClk);

    // DIVU 100/7, with busy-length measurement
    startDiv(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    busyCycles = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge iClk);
      if (!bus.oBusy) break;
      busyCycles++;
    end
    check("busy_cycles", 64'(busyCycles), 64'd33);
    repeat (2) @(negedge iClk);

    // signed sign handling
    startDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    waitDone();
    startDiv(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    waitDone();
    startDiv(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 33);
    waitDone();

    // overflow case, then restart in the oDone cycle
    startDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    waitDone();
    startDiv(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 33);
    waitDone();

    // zero divisor, signed and unsigned; then a nonzero divisor clears oDivZero
`ifdef DIV_ZERO_DETECT_EN
    startDiv(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, DZ, DZ_LAT);
`else
    startDiv(1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, DZ, DZ_LAT);
`endif
    waitDone();
    startDiv(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, DZ, DZ_LAT);
    waitDone();
    startDiv(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    waitDone();
    repeat (2) @(negedge iClk);

    // iStart while busy must be ignored
    startDiv(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);
    repeat (9) @(negedge iClk);
    bus.iStart    = 1'b1;
    bus.iDividend = 32'd99;
    bus.iDivisor  = 32'd4;
    @(negedge iClk);
    bus.iStart    = 1'b0;
    waitDone();
    repeat (3) @(negedge iClk);

    // reset mid-operation: no result pushed, so any oDone is flagged by the monitor
    bus.iStart    = 1'b1;
    bus.iSigned   = 1'b0;
    bus.iDividend = 32'd1000;
    bus.iDivisor  = 32'd3;
    @(negedge iClk);
    bus.iStart    = 1'b0;
    repeat (19) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check("abort_busy",      64'(bus.oBusy),      64'd0);
    check("abort_done",      64'(bus.oDone),      64'd0);
    check("abort_quotient",  64'(bus.oQuotient),  64'd0);
    check("abort_remainder", 64'(bus.oRemainder), 64'd0);
    check("abort_state",     64'(dbgState),       64'd0);
    repeat (3) @(negedge iClk);
    iRst_n = 1'b1;
    repeat (40) @(negedge iClk);

    startDiv(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
    waitDone();
    repeat (3) @(negedge iClk);

    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
